// File: rtl/pw_trigger_seq.sv
// rtl/pw_trigger_seq.sv - multi-pulse trigger sequencer fired by a pattern-match strobe
// Optional saturating miss counter output O_miss_count when PW_TRIGGER_MISS_COUNT_EN is defined.
module pw_trigger_seq #(
  parameter int pNUM_PULSES          = 4,
  parameter int pTRIGGER_DELAY_WIDTH = 20,
  parameter int pTRIGGER_WIDTH_WIDTH = 17
) (
  input  logic                                          fe_clk,
  input  logic                                          reset_n,
  input  logic                                          I_arm,
  input  logic                                          I_match,
  input  logic [4:0]                                    I_num_pulses,
  input  logic [pNUM_PULSES*pTRIGGER_DELAY_WIDTH-1:0]   I_delays,
  input  logic [pNUM_PULSES*pTRIGGER_WIDTH_WIDTH-1:0]   I_widths,
  output logic                                          O_trigger,
  output logic                                          O_busy,
  output logic [3:0]                                    O_pulse_index,
  output logic                                          O_missed
`ifdef PW_TRIGGER_MISS_COUNT_EN
  ,
  output logic [7:0]                                    O_miss_count
`endif
);

  localparam int DW = pTRIGGER_DELAY_WIDTH;
  localparam int WW = pTRIGGER_WIDTH_WIDTH;
  localparam logic [4:0] MAX_N = 5'(pNUM_PULSES);

  typedef enum logic [1:0] {IDLE, DELAY, PULSE} state_t;

  state_t                     state;
  logic [pNUM_PULSES*DW-1:0]  delays_q;
  logic [pNUM_PULSES*WW-1:0]  widths_q;
  logic [3:0]                 last_idx;
  logic [DW-1:0]              dly_cnt;
  logic [WW-1:0]              wid_cnt;
  logic [4:0]                 n_eff;
  logic [WW-1:0]              cur_width;
  logic [DW-1:0]              next_delay;
  logic                       accept;

  assign O_busy = (state != IDLE);
  assign accept = (state == IDLE) && I_arm && I_match;

  // Out-of-range pulse counts are clamped to the usable range 1..pNUM_PULSES.
  always_comb begin
    if (I_num_pulses == 5'd0)
      n_eff = 5'd1;
    else if (I_num_pulses > MAX_N)
      n_eff = MAX_N;
    else
      n_eff = I_num_pulses;
  end

  always_comb begin
    cur_width  = widths_q[WW-1:0];
    next_delay = delays_q[DW-1:0];
    for (int i = 0; i < pNUM_PULSES; i++) begin
      if (O_pulse_index == 4'(i))
        cur_width = widths_q[i*WW +: WW];
      if (O_pulse_index + 4'd1 == 4'(i))
        next_delay = delays_q[i*DW +: DW];
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      O_trigger     <= 1'b0;
      O_pulse_index <= 4'd0;
      O_missed      <= 1'b0;
      delays_q      <= '0;
      widths_q      <= '0;
      last_idx      <= 4'd0;
      dly_cnt       <= '0;
      wid_cnt       <= '0;
    end else begin
      O_missed <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= DELAY;
            delays_q      <= I_delays;
            widths_q      <= I_widths;
            last_idx      <= 4'(n_eff - 5'd1);
            dly_cnt       <= I_delays[DW-1:0];
            O_pulse_index <= 4'd0;
          end
        end
        default: begin
          if (I_match)
            O_missed <= 1'b1;
          if (!I_arm) begin
            state         <= IDLE;
            O_trigger     <= 1'b0;
            O_pulse_index <= 4'd0;
            dly_cnt       <= '0;
            wid_cnt       <= '0;
          end else if (state == DELAY) begin
            if (dly_cnt == '0) begin
              state     <= PULSE;
              O_trigger <= 1'b1;
              wid_cnt   <= (cur_width == '0) ? '0 : cur_width - 1'b1;
            end else begin
              dly_cnt <= dly_cnt - 1'b1;
            end
          end else begin
            if (wid_cnt == '0) begin
              O_trigger <= 1'b0;
              if (O_pulse_index == last_idx) begin
                state         <= IDLE;
                O_pulse_index <= 4'd0;
              end else begin
                // Gap counter is preloaded so the next rise lands max(delay,1) cycles after this fall.
                state         <= DELAY;
                O_pulse_index <= O_pulse_index + 4'd1;
                dly_cnt       <= (next_delay == '0) ? '0 : next_delay - 1'b1;
              end
            end else begin
              wid_cnt <= wid_cnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef PW_TRIGGER_MISS_COUNT_EN
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n)
      O_miss_count <= 8'd0;
    else if (accept)
      O_miss_count <= 8'd0;
    else if (O_busy && I_match && O_miss_count != 8'hFF)
      O_miss_count <= O_miss_count + 8'd1;
  end
`endif

endmodule

// File: doc/pw_trigger_seq.md
PW_TRIGGER_SEQ -- requirements
Module: pw_trigger_seq

Interface
REQ-001 SHALL have parameter pNUM_PULSES, default 4, max pulses per sequence (1..16).
REQ-002 SHALL have parameter pTRIGGER_DELAY_WIDTH, default 20, per-pulse delay width.
REQ-003 SHALL have parameter pTRIGGER_WIDTH_WIDTH, default 17, per-pulse width field width.
REQ-004 SHALL have port fe_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port I_arm  input  1  sequencer enabled while high.
REQ-007 SHALL have port I_match  input  1  one-cycle pattern-match strobe.
REQ-008 SHALL have port I_num_pulses  input  5  pulses per sequence.
REQ-009 SHALL have port I_delays  input  pNUM_PULSES*pTRIGGER_DELAY_WIDTH  flat delay array, pulse i at [i*W +: W].
REQ-010 SHALL have port I_widths  input  pNUM_PULSES*pTRIGGER_WIDTH_WIDTH  flat width array, same packing.
REQ-011 SHALL have port O_trigger  output  1  registered trigger output.
REQ-012 SHALL have port O_busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port O_pulse_index  output  4  index of current/next pulse.
REQ-014 SHALL have port O_missed  output  1  one-cycle strobe, match dropped while busy.

Function
REQ-015 SHALL implement states IDLE, DELAY, PULSE; O_busy = (state != IDLE).
REQ-016 SHALL, in IDLE with I_arm=1 and I_match=1 at edge n, latch I_num_pulses, I_delays, I_widths and enter DELAY with index 0.
REQ-017 SHALL ignore I_match in IDLE when I_arm=0; no state change, no O_missed.
REQ-018 SHALL treat latched num_pulses 0 as 1 and values above pNUM_PULSES as pNUM_PULSES.
REQ-019 SHALL drive O_trigger high for pulse 0 starting cycle n+1+delay[0]; delay[0]=0 gives one-cycle latency.
REQ-020 SHALL hold O_trigger high for exactly width[i] cycles; width 0 SHALL be treated as 1.
REQ-021 SHALL, for i>0, raise pulse i exactly max(delay[i],1) cycles after pulse i-1 falls (minimum one low cycle between pulses).
REQ-022 SHALL return to IDLE on the cycle O_trigger falls after the last pulse; O_pulse_index returns to 0.
REQ-023 SHALL, on I_match while busy, drop the match and pulse O_missed for one cycle; sequence unaffected.
REQ-024 SHALL, on I_arm falling while busy, abort: IDLE and O_trigger=0 on the next edge.
REQ-025 SHALL, on I_match in the same cycle the sequence returns to IDLE, count it as missed (no back-to-back restart).
REQ-026 SHALL use down-counters of the parameter widths; no counter SHALL wrap; input changes while busy have no effect.

Reset
REQ-027 SHALL, on reset_n low, asynchronously force state IDLE, O_trigger=0, O_busy=0, O_pulse_index=0, O_missed=0, counters 0.
REQ-028 SHALL, on reset_n low mid-pulse, drop O_trigger immediately without waiting for a clock edge.
REQ-029 SHALL release reset cleanly; first match accepted on the first edge with reset_n high.

Configuration
REQ-030 SHALL use macro PW_TRIGGER_MISS_COUNT_EN.
REQ-031 SHALL, with macro defined, add output O_miss_count (8 bits): saturating count of O_missed strobes, cleared by reset or by an accepted match in IDLE.
REQ-032 SHALL, without macro, omit O_miss_count port and its logic; all other behaviour identical.

Verification
REQ-033 SHALL cover: num_pulses=1, delay[0]=0, width[0]=1, match at edge n -> O_trigger high only cycle n+1, O_busy low cycle n+2.
REQ-034 SHALL cover: num_pulses=3, delays {5,2,0}, widths {3,1,4} -> highs at n+6..n+8, n+11, n+13..n+16; back in IDLE at n+17.
REQ-035 SHALL cover: second I_match during DELAY of pulse 0 -> O_missed one cycle, trigger timing unchanged, O_miss_count=1 if enabled.
REQ-036 SHALL cover: I_arm dropped during pulse 1 of a 4-pulse sequence -> O_trigger low next edge, IDLE, no further pulses.
REQ-037 SHALL cover: num_pulses=0 and num_pulses=20 with pNUM_PULSES=4 -> exactly 1 and 4 pulses respectively.
REQ-038 SHALL cover: reset_n asserted mid-pulse -> O_trigger low asynchronously, all outputs at reset values, next match works normally.
